// File: rtl/data_bus_bridge.sv
// Data-side bus bridge: splits CPU data accesses between the data SRAM and a
// small block of memory-mapped config registers (LED, switches, timer,
// compare, interrupt status). Read data returns one cycle after the request.
//
// Request semantics: cpu_en is a single-cycle "valid" with no back-pressure.
// Every cycle with cpu_en=1 is one complete access; cpu_wen=0 makes it a read.
// The bridge never stalls, so there is no ready signal. Read data is valid
// on the cycle after the request.
module data_bus_bridge #(
    parameter logic [15:0] CONF_HI   = 16'hBFAF,
    parameter logic [31:0] CMP_RESET = 32'hFFFF_FFFF
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        cpu_en,
    input  logic [3:0]  cpu_wen,
    input  logic [31:0] cpu_addr,
    input  logic [31:0] cpu_wdata,
    output logic [31:0] cpu_rdata,
    output logic        ram_en,
    output logic [3:0]  ram_wen,
    output logic [31:0] ram_addr,
    output logic [31:0] ram_wdata,
    input  logic [31:0] ram_rdata,
    input  logic [7:0]  switch,
    output logic [15:0] led,
    output logic        timer_irq
);

    localparam logic [15:0] OFF_LED     = 16'h0000;
    localparam logic [15:0] OFF_SWITCH  = 16'h0004;
    localparam logic [15:0] OFF_TIMER   = 16'h0008;
    localparam logic [15:0] OFF_COMPARE = 16'h000C;
    localparam logic [15:0] OFF_STATUS  = 16'h0010;

    logic        w_is_conf;
    logic        w_conf_acc;
    logic [15:0] w_off;
    logic [31:0] w_wmask;
    logic        w_wr_led;
    logic        w_wr_timer;
    logic        w_wr_compare;
    logic        w_wr_status;
    logic [31:0] w_timer_inc;
    logic        w_set;
    logic        w_clr;
    logic [31:0] w_conf_rdata;

    logic [15:0] r_led;
    logic [31:0] r_timer;
    logic [31:0] r_compare;
    logic        r_pending;
    logic [7:0]  r_sw_meta;
    logic [7:0]  r_sw_sync;
    logic        r_sel_q;
    logic [31:0] r_conf_q;

    // Address decode and SRAM request pass-through.
    assign w_is_conf  = (cpu_addr[31:16] == CONF_HI);
    assign w_conf_acc = cpu_en & w_is_conf;
    assign w_off      = cpu_addr[15:0];
    assign w_wmask    = {{8{cpu_wen[3]}}, {8{cpu_wen[2]}}, {8{cpu_wen[1]}}, {8{cpu_wen[0]}}};

    assign ram_en    = cpu_en & ~w_is_conf;
    assign ram_wen   = ram_en ? cpu_wen : 4'h0;
    assign ram_addr  = cpu_addr;
    assign ram_wdata = cpu_wdata;

    // Per-register write strobes; the byte mask decides which lanes change.
    assign w_wr_led     = w_conf_acc & (w_off == OFF_LED);
    assign w_wr_timer   = w_conf_acc & (w_off == OFF_TIMER);
    assign w_wr_compare = w_conf_acc & (w_off == OFF_COMPARE);
    assign w_wr_status  = w_conf_acc & (w_off == OFF_STATUS);

    assign w_timer_inc = r_timer + 32'd1;
    assign w_set       = (r_timer == r_compare);
    assign w_clr       = w_wr_status & cpu_wen[0] & cpu_wdata[0];

    // Config read mux, using register values before this cycle's updates.
    always_comb begin
        w_conf_rdata = 32'h0;
        if (w_is_conf) begin
            case (w_off)
                OFF_LED:     w_conf_rdata = {16'h0, r_led};
                OFF_SWITCH:  w_conf_rdata = {24'h0, r_sw_sync};
                OFF_TIMER:   w_conf_rdata = r_timer;
                OFF_COMPARE: w_conf_rdata = r_compare;
                OFF_STATUS:  w_conf_rdata = {31'h0, r_pending};
                default:     w_conf_rdata = 32'h0;
            endcase
        end
    end

    // LED register: only the two low byte lanes exist.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_led <= 16'h0;
        end else if (w_wr_led) begin
            r_led <= (r_led & ~w_wmask[15:0]) | (cpu_wdata[15:0] & w_wmask[15:0]);
        end
    end

    // Free-running timer; written lanes override the incremented value.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_timer <= 32'h0;
        end else if (w_wr_timer) begin
            r_timer <= (w_timer_inc & ~w_wmask) | (cpu_wdata & w_wmask);
        end else begin
            r_timer <= w_timer_inc;
        end
    end

    // Compare register, byte-lane writable.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_compare <= CMP_RESET;
        end else if (w_wr_compare) begin
            r_compare <= (r_compare & ~w_wmask) | (cpu_wdata & w_wmask);
        end
    end

    // Pending flag: a compare hit wins over a simultaneous write-1-to-clear.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_pending <= 1'b0;
        end else begin
            r_pending <= w_set | (r_pending & ~w_clr);
        end
    end

    // Two-flop synchroniser for the asynchronous board switches.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_sw_meta <= 8'h0;
            r_sw_sync <= 8'h0;
        end else begin
            r_sw_meta <= switch;
            r_sw_sync <= r_sw_meta;
        end
    end

    // Read-return state: captured on every access, held while idle.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_sel_q  <= 1'b0;
            r_conf_q <= 32'h0;
        end else if (cpu_en) begin
            r_sel_q  <= w_is_conf;
            r_conf_q <= w_conf_rdata;
        end
    end

    assign cpu_rdata = r_sel_q ? r_conf_q : ram_rdata;
    assign led       = r_led;
    assign timer_irq = r_pending;

endmodule

// File: tb/tb_data_bus_bridge.sv
// Bench for data_bus_bridge: directed scenarios plus a randomized run checked
// against a behavioural model of the register map and a small SRAM.
module tb_data_bus_bridge;

    localparam logic [15:0] CONF    = 16'hBFAF;
    localparam logic [31:0] CMP_RST = 32'hFFFF_FFFF;
    localparam logic [31:0] A_LED   = {CONF, 16'h0000};
    localparam logic [31:0] A_SW    = {CONF, 16'h0004};
    localparam logic [31:0] A_TIM   = {CONF, 16'h0008};
    localparam logic [31:0] A_CMP   = {CONF, 16'h000C};
    localparam logic [31:0] A_STS   = {CONF, 16'h0010};
    localparam logic [31:0] A_UNM   = {CONF, 16'h0020};

    // ---------------- clock / reset ----------------
    logic        clk       = 1'b0;
    logic        resetn    = 1'b0;
    logic        cpu_en    = 1'b0;
    logic [3:0]  cpu_wen   = 4'h0;
    logic [31:0] cpu_addr  = 32'h0;
    logic [31:0] cpu_wdata = 32'h0;
    logic [31:0] cpu_rdata;
    logic        ram_en;
    logic [3:0]  ram_wen;
    logic [31:0] ram_addr;
    logic [31:0] ram_wdata;
    logic [31:0] ram_rdata = 32'h0;
    logic [7:0]  switch    = 8'h3C;
    logic [15:0] led;
    logic        timer_irq;

    always #5 clk = ~clk;

    data_bus_bridge dut (
        .clk       (clk),
        .resetn    (resetn),
        .cpu_en    (cpu_en),
        .cpu_wen   (cpu_wen),
        .cpu_addr  (cpu_addr),
        .cpu_wdata (cpu_wdata),
        .cpu_rdata (cpu_rdata),
        .ram_en    (ram_en),
        .ram_wen   (ram_wen),
        .ram_addr  (ram_addr),
        .ram_wdata (ram_wdata),
        .ram_rdata (ram_rdata),
        .switch    (switch),
        .led       (led),
        .timer_irq (timer_irq)
    );

    int n_checks = 0;
    int n_fail   = 0;
    logic [31:0] exp_q[$];

    function automatic logic [31:0] lane_mask(input logic [3:0] w);
        return {{8{w[3]}}, {8{w[2]}}, {8{w[1]}}, {8{w[0]}}};
    endfunction

    // ---------------- SRAM emulation (answers the DUT's ram_* request) ----------------
    logic [31:0] sram [0:7] = '{default: 32'h0};

    always @(posedge clk) begin
        if (ram_en) begin
            if (ram_wen != 4'h0)
                sram[ram_addr[4:2]] <= (sram[ram_addr[4:2]] & ~lane_mask(ram_wen)) |
                                       (ram_wdata & lane_mask(ram_wen));
            else
                ram_rdata <= sram[ram_addr[4:2]];
        end
    end

    // ---------------- reference model ----------------
    logic [15:0] m_led;
    logic [31:0] m_timer;
    logic [31:0] m_compare;
    logic        m_pending;
    logic [7:0]  m_sw_hist[$];
    logic [31:0] m_mem [0:7] = '{default: 32'h0};
    logic        mv_conf;
    logic        mv_set;
    logic        mv_clr;
    logic [7:0]  mv_sw;
    logic [31:0] mv_mask;
    logic [31:0] mv_rd;
    logic [31:0] mv_next_t;

    always @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            m_led     = 16'h0;
            m_timer   = 32'h0;
            m_compare = CMP_RST;
            m_pending = 1'b0;
            m_sw_hist.delete();
            exp_q.delete();
        end else begin
            mv_conf = (cpu_addr[31:16] == CONF);
            mv_mask = lane_mask(cpu_wen);
            // Switch value visible now is the pin sampled two edges back.
            mv_sw = (m_sw_hist.size() >= 2) ? m_sw_hist[0] : 8'h0;
            case (cpu_addr[15:0])
                16'h0000: mv_rd = {16'h0, m_led};
                16'h0004: mv_rd = {24'h0, mv_sw};
                16'h0008: mv_rd = m_timer;
                16'h000C: mv_rd = m_compare;
                16'h0010: mv_rd = {31'h0, m_pending};
                default:  mv_rd = 32'h0;
            endcase
            if (cpu_en && cpu_wen == 4'h0)
                exp_q.push_back(mv_conf ? mv_rd : m_mem[cpu_addr[4:2]]);
            mv_set    = (m_timer == m_compare);
            mv_clr    = 1'b0;
            mv_next_t = m_timer + 32'd1;
            if (cpu_en && mv_conf) begin
                case (cpu_addr[15:0])
                    16'h0000: m_led = (m_led & ~mv_mask[15:0]) | (cpu_wdata[15:0] & mv_mask[15:0]);
                    16'h0008: mv_next_t = (mv_next_t & ~mv_mask) | (cpu_wdata & mv_mask);
                    16'h000C: m_compare = (m_compare & ~mv_mask) | (cpu_wdata & mv_mask);
                    16'h0010: mv_clr = cpu_wen[0] & cpu_wdata[0];
                    default: ;
                endcase
            end else if (cpu_en) begin
                m_mem[cpu_addr[4:2]] = (m_mem[cpu_addr[4:2]] & ~mv_mask) | (cpu_wdata & mv_mask);
            end
            m_timer   = mv_next_t;
            m_pending = mv_set | (m_pending & ~mv_clr);
            m_sw_hist.push_back(switch);
            if (m_sw_hist.size() > 2) void'(m_sw_hist.pop_front());
        end
    end

    // ---------------- driver ----------------
    logic       s_ram_en;
    logic [3:0] s_ram_wen;

    // One access cycle: drive at the falling edge, sample the combinational
    // SRAM request mid-cycle, return 1 time unit after the rising edge.
    task automatic access(input logic en, input logic [3:0] wen,
                          input logic [31:0] addr, input logic [31:0] wdata);
        @(negedge clk);
        cpu_en    = en;
        cpu_wen   = wen;
        cpu_addr  = addr;
        cpu_wdata = wdata;
        #1;
        s_ram_en  = ram_en;
        s_ram_wen = ram_wen;
        @(posedge clk);
        #1;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset;
        resetn = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_checks++; if (led !== 16'h0) begin n_fail++; $display("FAIL reset_led got=%h exp=0000", led); end
        n_checks++; if (timer_irq !== 1'b0) begin n_fail++; $display("FAIL reset_irq got=%b exp=0", timer_irq); end
        n_checks++; if (cpu_rdata !== 32'h0) begin n_fail++; $display("FAIL reset_rdata got=%h exp=00000000", cpu_rdata); end
        n_checks++; if (ram_en !== 1'b0) begin n_fail++; $display("FAIL reset_ram_en got=%b exp=0", ram_en); end
        // Release and read TIMER in the very first cycle, then again.
        @(negedge clk);
        resetn   = 1'b1;
        cpu_en   = 1'b1;
        cpu_wen  = 4'h0;
        cpu_addr = A_TIM;
        @(posedge clk);
        #1;
        n_checks++; if (cpu_rdata !== 32'h0) begin n_fail++; $display("FAIL timer_first got=%h exp=00000000", cpu_rdata); end
        access(1'b1, 4'h0, A_TIM, 32'h0);
        n_checks++; if (cpu_rdata !== 32'h1) begin n_fail++; $display("FAIL timer_second got=%h exp=00000001", cpu_rdata); end
        access(1'b0, 4'h0, 32'h0, 32'h0);
    endtask

    task automatic test_ram;
        access(1'b1, 4'hF, 32'h0000_1000, 32'hDEADBEEF);
        n_checks++; if (s_ram_en !== 1'b1 || s_ram_wen !== 4'hF) begin n_fail++;
            $display("FAIL ram_wr_req got en=%b wen=%h exp en=1 wen=f", s_ram_en, s_ram_wen); end
        access(1'b1, 4'h0, 32'h0000_1000, 32'h0);
        n_checks++; if (s_ram_en !== 1'b1 || s_ram_wen !== 4'h0) begin n_fail++;
            $display("FAIL ram_rd_req got en=%b wen=%h exp en=1 wen=0", s_ram_en, s_ram_wen); end
        n_checks++; if (cpu_rdata !== 32'hDEADBEEF) begin n_fail++; $display("FAIL ram_rdata got=%h exp=deadbeef", cpu_rdata); end
        access(1'b1, 4'h0, A_LED, 32'h0);
        n_checks++; if (s_ram_en !== 1'b0) begin n_fail++; $display("FAIL conf_rd_ram_en got=%b exp=0", s_ram_en); end
        access(1'b1, 4'hF, A_UNM, 32'hFFFF_FFFF);
        n_checks++; if (s_ram_en !== 1'b0 || s_ram_wen !== 4'h0) begin n_fail++;
            $display("FAIL conf_wr_ram_req got en=%b wen=%h exp en=0 wen=0", s_ram_en, s_ram_wen); end
        access(1'b0, 4'h0, 32'h0, 32'h0);
    endtask

    task automatic test_led;
        access(1'b1, 4'b0001, A_LED, 32'h1234_ABCD);
        n_checks++; if (led !== 16'h00CD) begin n_fail++; $display("FAIL led_byte0 got=%h exp=00cd", led); end
        access(1'b1, 4'h0, A_LED, 32'h0);
        n_checks++; if (cpu_rdata !== 32'h0000_00CD) begin n_fail++; $display("FAIL led_read got=%h exp=000000cd", cpu_rdata); end
        access(1'b1, 4'b1110, A_LED, 32'hFFFF_7700);
        n_checks++; if (led !== 16'h77CD) begin n_fail++; $display("FAIL led_byte1 got=%h exp=77cd", led); end
    endtask

    task automatic test_timer_irq;
        int first;
        access(1'b1, 4'hF, A_TIM, 32'd1000);
        access(1'b1, 4'hF, A_CMP, 32'd10);
        access(1'b1, 4'hF, A_TIM, 32'd5);
        first = 0;
        for (int k = 1; k <= 20; k++) begin
            access(1'b0, 4'h0, 32'h0, 32'h0);
            if (timer_irq === 1'b1) begin
                first = k;
                break;
            end
        end
        n_checks++; if (first != 6) begin n_fail++; $display("FAIL irq_rise_cycle got=%0d exp=6", first); end
        access(1'b1, 4'h0, A_TIM, 32'h0);
        n_checks++; if (cpu_rdata !== 32'd11) begin n_fail++; $display("FAIL irq_timer_val got=%0d exp=11", cpu_rdata); end
        access(1'b1, 4'h1, A_STS, 32'h1);
        n_checks++; if (timer_irq !== 1'b0) begin n_fail++; $display("FAIL irq_w1c got=%b exp=0", timer_irq); end
        // Clear lands in the same cycle as a compare hit.
        access(1'b1, 4'hF, A_TIM, 32'd100);
        access(1'b1, 4'hF, A_CMP, 32'd102);
        access(1'b0, 4'h0, 32'h0, 32'h0);
        access(1'b1, 4'h1, A_STS, 32'h1);
        n_checks++; if (timer_irq !== 1'b1) begin n_fail++; $display("FAIL irq_set_prio got=%b exp=1", timer_irq); end
        access(1'b1, 4'hF, A_CMP, 32'd500);
        n_checks++; if (timer_irq !== 1'b1) begin n_fail++; $display("FAIL irq_cmp_wr_keeps got=%b exp=1", timer_irq); end
        access(1'b1, 4'h1, A_STS, 32'h1);
        n_checks++; if (timer_irq !== 1'b0) begin n_fail++; $display("FAIL irq_clear2 got=%b exp=0", timer_irq); end
    endtask

    task automatic test_timer_wrap;
        access(1'b1, 4'hF, A_TIM, 32'hFFFF_FFFE);
        access(1'b1, 4'h0, A_TIM, 32'h0);
        n_checks++; if (cpu_rdata !== 32'hFFFF_FFFE) begin n_fail++; $display("FAIL wrap_r0 got=%h exp=fffffffe", cpu_rdata); end
        access(1'b1, 4'h0, A_TIM, 32'h0);
        n_checks++; if (cpu_rdata !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL wrap_r1 got=%h exp=ffffffff", cpu_rdata); end
        access(1'b1, 4'h0, A_TIM, 32'h0);
        n_checks++; if (cpu_rdata !== 32'h0) begin n_fail++; $display("FAIL wrap_r2 got=%h exp=00000000", cpu_rdata); end
        access(1'b1, 4'b0010, A_TIM, 32'h0000_AB00);
        access(1'b1, 4'h0, A_TIM, 32'h0);
        n_checks++; if (cpu_rdata !== 32'h0000_AB02) begin n_fail++; $display("FAIL timer_lane1 got=%h exp=0000ab02", cpu_rdata); end
    endtask

    task automatic test_switch;
        switch = 8'hA5;
        access(1'b0, 4'h0, 32'h0, 32'h0);
        access(1'b1, 4'h0, A_SW, 32'h0);
        n_checks++; if (cpu_rdata !== 32'h0000_003C) begin n_fail++; $display("FAIL sw_old got=%h exp=0000003c", cpu_rdata); end
        access(1'b1, 4'h0, A_SW, 32'h0);
        n_checks++; if (cpu_rdata !== 32'h0000_00A5) begin n_fail++; $display("FAIL sw_new got=%h exp=000000a5", cpu_rdata); end
        access(1'b0, 4'h0, 32'h0, 32'h0);
    endtask

    task automatic test_reset_mid;
        access(1'b1, 4'b0011, A_LED, 32'h0000_FFFF);
        access(1'b1, 4'hF, A_TIM, 32'd50);
        access(1'b1, 4'hF, A_CMP, 32'd51);
        access(1'b0, 4'h0, 32'h0, 32'h0);
        n_checks++; if (timer_irq !== 1'b1 || led !== 16'hFFFF) begin n_fail++;
            $display("FAIL pre_reset got irq=%b led=%h exp irq=1 led=ffff", timer_irq, led); end
        @(negedge clk);
        #1 resetn = 1'b0;
        #1;
        n_checks++; if (led !== 16'h0 || timer_irq !== 1'b0) begin n_fail++;
            $display("FAIL async_reset got led=%h irq=%b exp led=0000 irq=0", led, timer_irq); end
        #1 resetn = 1'b1;
        access(1'b0, 4'h0, 32'h0, 32'h0);
        n_checks++; if (cpu_rdata !== ram_rdata) begin n_fail++;
            $display("FAIL post_reset_src got=%h exp=%h", cpu_rdata, ram_rdata); end
        access(1'b1, 4'h0, A_CMP, 32'h0);
        n_checks++; if (cpu_rdata !== CMP_RST) begin n_fail++; $display("FAIL cmp_reset got=%h exp=%h", cpu_rdata, CMP_RST); end
        access(1'b1, 4'h0, A_UNM, 32'h0);
        n_checks++; if (cpu_rdata !== 32'h0) begin n_fail++; $display("FAIL unmapped got=%h exp=00000000", cpu_rdata); end
        access(1'b1, 4'h0, A_STS, 32'h0);
        n_checks++; if (cpu_rdata !== 32'h0) begin n_fail++; $display("FAIL status_reset got=%h exp=00000000", cpu_rdata); end
        access(1'b0, 4'h0, 32'h0, 32'h0);
    endtask

    task automatic test_random;
        logic        en;
        logic [3:0]  wen;
        logic [31:0] addr;
        logic [31:0] exp_v;
        logic [15:0] offs [0:6];
        offs = '{16'h0000, 16'h0004, 16'h0008, 16'h000C, 16'h0010, 16'h0014, 16'h0020};
        exp_q.delete();
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 7) == 0) switch = 8'($urandom);
            en   = ($urandom_range(0, 3) != 0);
            wen  = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(1, 15));
            addr = ($urandom_range(0, 1) == 0) ? {CONF, offs[$urandom_range(0, 6)]}
                                               : (32'h0000_1000 + 32'(4 * $urandom_range(0, 7)));
            access(en, wen, addr, $urandom);
            if (en && wen == 4'h0) begin
                n_checks++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL rand_read[%0d] got=%h exp=<none queued>", i, cpu_rdata);
                end else begin
                    exp_v = exp_q.pop_front();
                    if (cpu_rdata !== exp_v) begin n_fail++;
                        $display("FAIL rand_read[%0d] addr=%h got=%h exp=%h", i, addr, cpu_rdata, exp_v); end
                end
            end
            n_checks++; if (led !== m_led) begin n_fail++; $display("FAIL rand_led[%0d] got=%h exp=%h", i, led, m_led); end
            n_checks++; if (timer_irq !== m_pending) begin n_fail++;
                $display("FAIL rand_irq[%0d] got=%b exp=%b", i, timer_irq, m_pending); end
        end
        access(1'b0, 4'h0, 32'h0, 32'h0);
    endtask

    // ---------------- sequence and final report ----------------
    initial begin
        test_reset();
        test_ram();
        test_led();
        test_timer_irq();
        test_timer_wrap();
        test_switch();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=completion");
        $fatal(1, "watchdog expired");
    end

endmodule
